// File: rtl/fpu_seq_responder.sv
// fpu_seq_responder: handshaked arithmetic unit (add/sub/and in one cycle,
// unsigned multiply by iterative shift-add, one multiplier bit per cycle).
module fpu_seq_responder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 zero,
    output logic [1:0]           op_out
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   count_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [RW-1:0]   acc_q;
    logic [RW-1:0]   acc_next;
    logic [RW-1:0]   alu_result;
    logic            accept;
    logic            mul_last;

    // Next-state decode, single-cycle ALU result and next partial product.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        mul_last   = 1'b0;
        alu_result = '0;
        acc_next   = acc_q + (b_q[count_q] ? (RW'(a_q) << count_q) : RW'(0));

        // Unknown sel bits fall through to the AND branch.
        case (sel)
            2'b00:   alu_result = RW'(a) + RW'(b);
            2'b01:   alu_result = RW'(a) - RW'(b);
            2'b10:   alu_result = '0;
            default: alu_result = {{WIDTH{1'b0}}, a & b};
        endcase

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    case (sel)
                        2'b10:   state_d = MUL;
                        default: state_d = DONE;
                    endcase
                end
            end
            MUL: begin
                if (count_q == CW'(WIDTH - 1)) begin
                    mul_last = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (rsp_valid && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, multiplier iteration and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
            op_out    <= 2'b00;
            count_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
        end else begin
            req_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == DONE);

            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                count_q <= '0;
                acc_q   <= '0;
                if (state_d == DONE) begin
                    y      <= alu_result;
                    zero   <= (alu_result == '0);
                    op_out <= sel;
                end
            end

            if (state_q == MUL) begin
                acc_q   <= acc_next;
                count_q <= count_q + CW'(1);
                if (mul_last) begin
                    y      <= acc_next;
                    zero   <= (acc_next == '0);
                    op_out <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_seq_responder.sv
// tb_fpu_seq_responder: directed vectors, handshake corner cases and random
// operations checked against an arithmetic reference model.
module tb_fpu_seq_responder;

    localparam int unsigned WIDTH = 8;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] y;
    logic        zero;
    logic [1:0]  op_out;

    int n_assert = 0;
    int n_fail   = 0;

    fpu_seq_responder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .y         (y),
        .zero      (zero),
        .op_out    (op_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  sel;
        logic [15:0] y;
        logic        zero;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, truncated to the 16-bit result.
    function automatic logic [15:0] model_y(input logic [7:0] ma, input logic [7:0] mb,
                                            input logic [1:0] ms);
        int ai;
        int bi;
        int r;
        ai = int'(ma);
        bi = int'(mb);
        case (ms)
            2'd0:    r = ai + bi;
            2'd1:    r = ai - bi;
            2'd2:    r = ai * bi;
            default: r = ai & bi;
        endcase
        return 16'(r);
    endfunction

    function automatic int model_lat(input logic [1:0] ms);
        return (ms == 2'b10) ? int'(WIDTH) + 1 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE, wait for the response, hold it 'hold'
    // cycles, then complete the handshake.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb2, input logic [1:0] ts,
                          input logic [15:0] exp_y, input logic exp_zero, input int hold,
                          input string name);
        logic [15:0] y0;
        int lat;
        chk({name, " req_ready idle"}, 32'(req_ready), 32'd1);
        a = ta;
        b = tb2;
        sel = ts;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        sel = 2'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            chk({name, " req_ready busy"}, 32'(req_ready), 32'd0);
            tick();
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(model_lat(ts)));
        chk({name, " y"}, 32'(y), 32'(exp_y));
        chk({name, " zero"}, 32'(zero), 32'(exp_zero));
        chk({name, " op_out"}, 32'(op_out), 32'(ts));
        y0 = y;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({name, " hold y"}, 32'(y), 32'(y0));
            chk({name, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({name, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({name, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
        chk({name, " req_ready back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [1:0]  rs;
        logic [15:0] ry;

        vecs[0]  = '{8'h0C, 8'h03, 2'b00, 16'h000F, 1'b0};
        vecs[1]  = '{8'h0C, 8'h03, 2'b01, 16'h0009, 1'b0};
        vecs[2]  = '{8'h03, 8'h0C, 2'b01, 16'hFFF7, 1'b0};
        vecs[3]  = '{8'h0C, 8'h03, 2'b10, 16'h0024, 1'b0};
        vecs[4]  = '{8'hFF, 8'hFF, 2'b10, 16'hFE01, 1'b0};
        vecs[5]  = '{8'h0C, 8'h03, 2'b11, 16'h0000, 1'b1};
        vecs[6]  = '{8'h00, 8'hFF, 2'b10, 16'h0000, 1'b1};
        vecs[7]  = '{8'h00, 8'h00, 2'b01, 16'h0000, 1'b1};
        vecs[8]  = '{8'h01, 8'hFF, 2'b01, 16'hFF02, 1'b0};
        vecs[9]  = '{8'h80, 8'h02, 2'b10, 16'h0100, 1'b0};
        vecs[10] = '{8'hFF, 8'hFF, 2'b00, 16'h01FE, 1'b0};

        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        a = '0;
        b = '0;
        sel = '0;
        #12;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset y", 32'(y), 32'd0);
        chk("reset zero", 32'(zero), 32'd0);
        chk("reset op_out", 32'(op_out), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // rsp_ready with no response pending has no effect.
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("idle rsp_ready rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle rsp_ready req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].y, vecs[i].zero, 0,
                   $sformatf("vec%0d", i));
        end

        // Response held five cycles while another request waits; it is taken
        // only after the response handshake, from IDLE.
        a = 8'h0C;
        b = 8'h03;
        sel = 2'b00;
        req_valid = 1'b1;
        tick();
        a = 8'h05;
        b = 8'h06;
        sel = 2'b00;
        chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp y", 32'(y), 32'h000F);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold y", 32'(y), 32'h000F);
            chk("bp hold rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp hold req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp idle rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp idle req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("bp second rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp second y", 32'(y), 32'h000B);
        chk("bp second op_out", 32'(op_out), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp second done", 32'(req_ready), 32'd1);

        // Reset in the middle of a multiply (count=4) after a non-zero result.
        run_op(8'hFF, 8'hFF, 2'b00, 16'h01FE, 1'b0, 0, "pre-reset");
        a = 8'h0C;
        b = 8'h03;
        sel = 2'b10;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        chk("mid-mul req_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("async rst req_ready", 32'(req_ready), 32'd1);
        chk("async rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async rst y", 32'(y), 32'd0);
        chk("async rst zero", 32'(zero), 32'd0);
        chk("async rst op_out", 32'(op_out), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_op(8'h0C, 8'h03, 2'b00, 16'h000F, 1'b0, 0, "post-reset add");

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 2'($urandom);
            if (i % 8 == 0) ra = 8'h00;
            if (i % 8 == 1) rb = 8'hFF;
            ry = model_y(ra, rb, rs);
            run_op(ra, rb, rs, ry, (ry == 16'h0000), int'($urandom_range(0, 3)),
                   $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
